// File: rtl/fd_reg_pkg.sv
// Shared constants and types for the Fetch/Decode pipeline register.
package fd_reg_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] ERET_WORD = 32'h42000018;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // Everything the Decode stage sees from this register.
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exc;
    logic             bd;
    logic             valid;
  } fd_d_t;

  // A bubble: no instruction, no exception, never a delay slot.
  function automatic fd_d_t make_bubble(input logic [31:0] pc);
    fd_d_t b;
    b.pc    = pc;
    b.instr = 32'h0;
    b.exc   = EXC_INT;
    b.bd    = 1'b0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fd_reg_if.sv
// Fetch-side inputs and Decode-side outputs of the F/D register.
interface fd_reg_if;
  import fd_reg_pkg::*;

  logic             i_en;
  logic             i_flush;
  logic [31:0]      i_PC_F;
  logic [31:0]      i_instr_F;
  logic [EXC_W-1:0] i_ExcCode_F;

  logic [31:0]      o_PC_D;
  logic [31:0]      o_instr_D;
  logic [EXC_W-1:0] o_ExcCode_D;
  logic             o_BD_D;
  logic             o_valid_D;

  // Pipeline control / fetch side drives the inputs and observes Decode.
  modport master (
    output i_en, i_flush, i_PC_F, i_instr_F, i_ExcCode_F,
    input  o_PC_D, o_instr_D, o_ExcCode_D, o_BD_D, o_valid_D
  );

  // The register itself.
  modport slave (
    input  i_en, i_flush, i_PC_F, i_instr_F, i_ExcCode_F,
    output o_PC_D, o_instr_D, o_ExcCode_D, o_BD_D, o_valid_D
  );
endinterface

// File: rtl/fd_reg_bj_detect.sv
// Flags branch and jump instructions, i.e. those that own a delay slot.
// Also used by the Decode-stage next-PC logic.
module fd_reg_bj_detect
  import fd_reg_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_bj
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused;

  assign w_op = instr[31:26];
  assign w_fn = instr[5:0];
  // Register/immediate fields play no part in the classification.
  assign w_unused = ^instr[25:6];

  // Classify by opcode; SPECIAL needs the funct field to spot jr/jalr.
  always_comb begin
    is_bj = 1'b0;
    case (w_op)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_bj = 1'b1;
      OP_SPECIAL: is_bj = (w_fn == FN_JR) || (w_fn == FN_JALR);
      default:    is_bj = 1'b0;
    endcase
  end

endmodule

// File: rtl/fd_reg.sv
// Fetch/Decode pipeline register: stall, flush, eret bubble, AdEL masking
// and branch-delay-slot flag generation.
module fd_reg
  import fd_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter logic [31:0] FLUSH_PC = 32'h00000000
) (
  input  logic     clk,
  input  logic     reset,
  fd_reg_if.slave  bus
);

  fd_d_t r_d;
  logic  w_is_bj;

  // BD for the incoming instruction is decided by what Decode holds now.
  fd_reg_bj_detect u_bj_detect (
    .instr (r_d.instr),
    .is_bj (w_is_bj)
  );

  // Priority chain: reset, flush, stall, eret bubble, normal load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d <= make_bubble(RESET_PC);
    end else if (bus.i_flush) begin
      r_d <= make_bubble(FLUSH_PC);
    end else if (bus.i_en) begin
      if (r_d.instr == ERET_WORD) begin
        // eret has no delay slot: the word fetched behind it is dropped.
        r_d <= make_bubble(bus.i_PC_F);
      end else begin
        r_d.pc    <= bus.i_PC_F;
        r_d.exc   <= bus.i_ExcCode_F;
        r_d.valid <= 1'b1;
        // A faulting fetch must never be decoded, so it becomes a nop,
        // which in turn keeps its successor from being flagged as a slot.
        r_d.instr <= (bus.i_ExcCode_F == EXC_ADEL) ? 32'h0 : bus.i_instr_F;
        r_d.bd    <= w_is_bj && r_d.valid;
      end
    end
  end

  assign bus.o_PC_D      = r_d.pc;
  assign bus.o_instr_D   = r_d.instr;
  assign bus.o_ExcCode_D = r_d.exc;
  assign bus.o_BD_D      = r_d.bd;
  assign bus.o_valid_D   = r_d.valid;

endmodule

// File: tb/tb_fd_reg.sv
// Scoreboard bench for fd_reg: driver pushes expected Decode contents per
// clock edge, a monitor pops and compares after each edge.
module tb_fd_reg;

  localparam logic [31:0] RST_PC = 32'h00003000;
  localparam logic [31:0] FL_PC  = 32'h00000000;
  localparam logic [31:0] ERET   = 32'h42000018;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } exp_t;

  logic clk;
  logic reset;
  fd_reg_if bus ();

  fd_reg #(.RESET_PC(RST_PC), .FLUSH_PC(FL_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_step   = 0;
  exp_t expq[$];

  // reference Decode contents
  logic [31:0] m_pc, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  function automatic bit ref_is_bj(logic [31:0] w);
    int op;
    int fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  function automatic void model_reset();
    m_pc = RST_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
  endfunction

  // Drive one cycle of fetch inputs, predict the result of the coming edge.
  task automatic step(input bit en, input bit flush, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [4:0] exc);
    exp_t e;
    bus.i_en = en;
    bus.i_flush = flush;
    bus.i_PC_F = pc;
    bus.i_instr_F = instr;
    bus.i_ExcCode_F = exc;
    if (flush) begin
      m_pc = FL_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    end else if (en) begin
      if (m_instr == ERET) begin
        m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
      end else begin
        m_bd    = m_valid && ref_is_bj(m_instr);
        m_pc    = pc;
        m_instr = (exc == 5'd4) ? 32'h0 : instr;
        m_exc   = exc;
        m_valid = 1'b1;
      end
    end
    n_step++;
    e.idx = n_step; e.pc = m_pc; e.instr = m_instr; e.exc = m_exc;
    e.bd = m_bd; e.valid = m_valid;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic void check_reset_outputs(string tag);
    chk({tag, " PC_D"},    bus.o_PC_D, RST_PC);
    chk({tag, " instr_D"}, bus.o_instr_D, 32'h0);
    chk({tag, " Exc_D"},   32'(bus.o_ExcCode_D), 32'h0);
    chk({tag, " BD_D"},    32'(bus.o_BD_D), 32'h0);
    chk({tag, " valid_D"}, 32'(bus.o_valid_D), 32'h0);
  endfunction

  // Monitor: every edge updates Decode, so compare after each one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk($sformatf("s%0d PC_D", e.idx),    bus.o_PC_D, e.pc);
        chk($sformatf("s%0d instr_D", e.idx), bus.o_instr_D, e.instr);
        chk($sformatf("s%0d Exc_D", e.idx),   32'(bus.o_ExcCode_D), 32'(e.exc));
        chk($sformatf("s%0d BD_D", e.idx),    32'(bus.o_BD_D), 32'(e.bd));
        chk($sformatf("s%0d valid_D", e.idx), 32'(bus.o_valid_D), 32'(e.valid));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: rand_instr = w;
      1: rand_instr = {6'h04 + 6'($urandom_range(0, 3)), w[25:0]};
      2: rand_instr = {6'h01, w[25:0]};
      3: rand_instr = {6'h02 + 6'($urandom_range(0, 1)), w[25:0]};
      4: rand_instr = {6'h00, w[25:6], 6'h08 + 6'($urandom_range(0, 1))};
      5: rand_instr = ERET;
      6: rand_instr = 32'h0;
      default: rand_instr = {6'h00, w[25:0]};
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    bus.i_en = 1'b0; bus.i_flush = 1'b0;
    bus.i_PC_F = 0; bus.i_instr_F = 0; bus.i_ExcCode_F = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk); #2;
    reset = 1'b1;

    // first edge after release is a normal load
    step(1, 0, 32'h3000, 32'h24010001, 0);
    // beq, then its delay slot, then a jal (not a slot)
    step(1, 0, 32'h3004, 32'h10220003, 0);
    step(1, 0, 32'h3008, 32'h00000000, 0);
    step(1, 0, 32'h300c, 32'h0C000C00, 0);
    // stall 3 cycles with jal in Decode; inputs change underneath
    for (int i = 0; i < 3; i++) step(0, 0, $urandom, $urandom, 5'd4);
    step(1, 0, 32'h3010, 32'h24010003, 0);
    // AdEL on a j-shaped word, then its successor must not be a slot
    step(1, 0, 32'h3002, 32'h08000c00, 5'd4);
    step(1, 0, 32'h3004, 32'h24010005, 0);
    // eret bubble and the instruction after the bubble
    step(1, 0, 32'h3018, ERET, 0);
    step(1, 0, 32'h3020, 32'h24010004, 0);
    step(1, 0, 32'h3024, 32'h24010006, 0);
    // branch in Decode, flush during stall
    step(1, 0, 32'h3028, 32'h10220003, 0);
    step(0, 1, 32'h302c, 32'h24010007, 0);
    // flush with eret in Decode
    step(1, 0, 32'h3030, ERET, 0);
    step(1, 1, 32'h3034, 32'h24010008, 0);
    step(1, 0, 32'h3038, 32'h24010009, 0);

    // asynchronous reset mid-cycle
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held");
    @(negedge clk); #2;
    reset = 1'b1;
    step(1, 0, 32'h3000, 32'h24010001, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit en, fl;
      logic [4:0] exc;
      en  = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 19) == 0);
      exc = ($urandom_range(0, 9) == 0) ? 5'd4 : 5'd0;
      step(en, fl, $urandom, rand_instr(), exc);
    end

    bus.i_en = 1'b0;
    bus.i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fd_reg.md
# fd_reg

Fetch/Decode pipeline register sitting directly downstream of the PC register and instruction memory in the five-stage MIPS pipeline. Captures the fetched PC, instruction word and fetch exception code each cycle and presents them to the Decode stage. It supports:
- stalls from the hazard unit;
- flushes from CP0;
- insertion of a bubble behind `eret`;
- masking of faulting fetches;
- generation of the branch-delay-slot (BD) flag that CP0 needs for EPC.

## Interface
Parameters:
- `RESET_PC`, 32'h00003000, PC value loaded on reset.
- `FLUSH_PC`, 32'h00000000, PC value loaded on flush.

Ports:
- `clk` input 1: pipeline clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_en` input 1: 1 = advance; 0 = stall and hold all outputs.
- `i_flush` input 1: CP0 exception/interrupt flush; loads a bubble.
- `i_PC_F` input 32: PC of the instruction being fetched.
- `i_instr_F` input 32: instruction word from instruction memory.
- `i_ExcCode_F` input 5: fetch exception code; `Int` (0) = none, `AdEL` (4) = bad fetch address.
- `o_PC_D` output 32: PC of the Decode-stage instruction.
- `o_instr_D` output 32: Decode-stage instruction word.
- `o_ExcCode_D` output 5: exception code carried into Decode.
- `o_BD_D` output 1: Decode instruction is in a branch/jump delay slot.
- `o_valid_D` output 1: 0 = bubble inserted by reset, flush or `eret`.

## Operation
Update priority, highest first:
- **Reset** (`reset`=0, asynchronous): `o_PC_D`=`RESET_PC`, `o_instr_D`=0, `o_ExcCode_D`=0, `o_BD_D`=0, `o_valid_D`=0.
- **Flush** (`i_flush`=1): `o_PC_D`=`FLUSH_PC`, `o_instr_D`=0, `o_ExcCode_D`=0, `o_BD_D`=0, `o_valid_D`=0. Flush applies even when `i_en`=0.
- **Stall** (`i_en`=0): every output holds its value.
- **Eret bubble**: applies when `o_instr_D`==32'h42000018 (`eret`) and `i_en`=1.
  - The instruction fetched behind `eret` is discarded.
  - `o_PC_D`=`i_PC_F`; `o_instr_D`=0, `o_ExcCode_D`=0, `o_BD_D`=0, `o_valid_D`=0.
- **Normal load**:
  - `o_PC_D`=`i_PC_F`, `o_ExcCode_D`=`i_ExcCode_F`, `o_valid_D`=1.
  - `o_instr_D`=`i_instr_F`, except when `i_ExcCode_F`==`AdEL`, in which case it is forced to 0 (nop) so the bad word is never decoded.
  - `o_BD_D` = `is_bj(o_instr_D)`, evaluated on the value held in Decode before the edge.

`is_bj` is true for any of the following:
- opcodes 6'h01 (regimm), 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07;
- opcode 6'h00 with funct 6'h08 (`jr`) or 6'h09 (`jalr`).

A bubble (`o_valid_D`=0) or an `eret` in Decode never sets BD on its successor. `eret` has no delay slot.

## Timing
- Latency: exactly one cycle from F inputs to D outputs. There is no combinational path from inputs to outputs.
- Stall followed by release: the instruction held during the stall moves to Execute. The F inputs sampled on the release edge enter Decode. BD uses the held Decode instruction, so a branch held across N stall cycles still flags its delay slot.
- Flush and stall in the same cycle: flush wins.
- Flush with `eret` in Decode: flush wins; the result is identical to a flush.
- `AdEL` fetch of a branch-shaped word: the instruction is masked to nop, so its successor gets `o_BD_D`=0.
- Reset deasserts asynchronously. The first rising edge with `reset`=1 performs a normal load.

## Structure
- `macrodefine.v` holds `ExcCode` constants (`Int`, `AdEL`), the `ERET` word 32'h42000018, and the opcode/funct constants used by `is_bj`.
- One combinational sub-module, `bj_detect`: input `instr[31:0]`, output `is_bj`. It is reused by the Decode-stage next-PC logic.
- `fd_reg` itself contains a single always block with asynchronous reset and the priority chain above.

## Test plan
- **Reset**: assert `reset`=0 mid-cycle → all outputs at reset values immediately. Release with `i_PC_F`=0x3000, `i_instr_F`=0x24010001 → next edge: `o_PC_D`=0x3000, `o_valid_D`=1, `o_BD_D`=0.
- **Delay slot**: load `beq` 0x10220003 @0x3004, then 0x00000000 @0x3008 → second instruction has `o_BD_D`=1; the following instruction has `o_BD_D`=0.
- **Stall**: hold `i_en`=0 for 3 cycles with `jal` in Decode → outputs constant. On release, the slot instruction @0x3010 gets `o_BD_D`=1.
- **AdEL fetch**: `i_ExcCode_F`=4, `i_instr_F`=0x08000c00, `i_PC_F`=0x3002 → `o_instr_D`=0, `o_ExcCode_D`=4, `o_PC_D`=0x3002, `o_valid_D`=1.
- **Eret**: `eret` in Decode, `i_PC_F`=0x3020 → next edge: `o_PC_D`=0x3020, `o_instr_D`=0, `o_valid_D`=0.
- **Flush vs stall**: `i_flush`=1 with `i_en`=0 → `o_PC_D`=0, all other outputs 0.
